// File: rtl/search_result_log_if.sv
// Bus between the binary-search engine / user controls and the search result log.
// The master drives search events and user pulses; the slave (the log) returns the viewed entry.
interface search_result_log_if;
    logic       start;
    logic [7:0] key_in;
    logic       done;
    logic [4:0] loc;
    logic       found;
    logic [7:0] cycles;
    logic       next;
    logic       prev;
    logic       clear;
    logic [7:0] rd_key;
    logic [4:0] rd_loc;
    logic       rd_found;
    logic [7:0] rd_cycles;
    logic [2:0] rd_index;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    modport master (
        output start, key_in, done, loc, found, cycles, next, prev, clear,
        input  rd_key, rd_loc, rd_found, rd_cycles, rd_index, count, empty, full,
               hit_count, miss_count
    );

    modport slave (
        input  start, key_in, done, loc, found, cycles, next, prev, clear,
        output rd_key, rd_loc, rd_found, rd_cycles, rd_index, count, empty, full,
               hit_count, miss_count
    );
endinterface

// File: rtl/search_result_log.sv
// Eight-deep circular log of binary-search results with a browsable view pointer
// and saturating hit/miss totals.
module search_result_log (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    search_result_log_if.slave    bus
);
    typedef struct packed {
        logic [7:0] key;
        logic [4:0] loc;
        logic       found;
        logic [7:0] cycles;
    } entry_t;

    entry_t     mem_q [8];
    logic       done_prev_q;
    logic       pending_q,  pending_d;
    logic [7:0] pend_key_q, pend_key_d;
    logic [2:0] wr_ptr_q,   wr_ptr_d;
    logic [2:0] rd_index_q, rd_index_d;
    logic [3:0] count_q,    count_d;
    logic [7:0] hit_q,      hit_d;
    logic [7:0] miss_q,     miss_d;

    logic       log_ev;
    logic       can_older;
    logic [2:0] rd_ptr;
    entry_t     view;

    // A log needs a fresh done edge and an outstanding start; clear suppresses the write.
    assign log_ev    = bus.done && !done_prev_q && pending_q;
    assign can_older = ({1'b0, rd_index_q} + 4'd1) < count_q;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
        pending_d  = pending_q;
        pend_key_d = pend_key_q;
        wr_ptr_d   = wr_ptr_q;
        rd_index_d = rd_index_q;
        count_d    = count_q;
        hit_d      = hit_q;
        miss_d     = miss_q;

        if (bus.clear) begin
            pending_d  = 1'b0;
            wr_ptr_d   = 3'd0;
            rd_index_d = 3'd0;
            count_d    = 4'd0;
            hit_d      = 8'd0;
            miss_d     = 8'd0;
        end else begin
            if (log_ev) begin
                wr_ptr_d   = wr_ptr_q + 3'd1;
                rd_index_d = 3'd0;
                pending_d  = 1'b0;
                if (count_q != 4'd8)
                    count_d = count_q + 4'd1;
                if (bus.found) begin
                    if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
                end else begin
                    if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
                end
            end else if (bus.next && !bus.prev) begin
                if (can_older) rd_index_d = rd_index_q + 3'd1;
            end else if (bus.prev && !bus.next) begin
                if (rd_index_q != 3'd0) rd_index_d = rd_index_q - 3'd1;
            end

            // A start coinciding with a log restarts after the old key was consumed.
            if (bus.start) begin
                pending_d  = 1'b1;
                pend_key_d = bus.key_in;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            done_prev_q <= 1'b0;
            pending_q   <= 1'b0;
            pend_key_q  <= 8'd0;
            wr_ptr_q    <= 3'd0;
            rd_index_q  <= 3'd0;
            count_q     <= 4'd0;
            hit_q       <= 8'd0;
            miss_q      <= 8'd0;
        end else begin
            done_prev_q <= bus.done;
            pending_q   <= pending_d;
            pend_key_q  <= pend_key_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_index_q  <= rd_index_d;
            count_q     <= count_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
        end
    end

    // NOTE: the entry store is deliberately not reset; slots beyond count are never shown.
    always_ff @(posedge CLOCK_50) begin
        if (!reset && log_ev && !bus.clear)
            mem_q[wr_ptr_q] <= '{key: pend_key_q, loc: bus.loc, found: bus.found, cycles: bus.cycles};
    end

    assign rd_ptr = wr_ptr_q - 3'd1 - rd_index_q;
    assign view   = (count_q == 4'd0) ? '0 : mem_q[rd_ptr];

    assign bus.rd_key     = view.key;
    assign bus.rd_loc     = view.loc;
    assign bus.rd_found   = view.found;
    assign bus.rd_cycles  = view.cycles;
    assign bus.rd_index   = rd_index_q;
    assign bus.count      = count_q;
    assign bus.empty      = (count_q == 4'd0);
    assign bus.full       = (count_q == 4'd8);
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
endmodule

// File: doc/search_result_log.md
SEARCH_RESULT_LOG -- requirements
Module: search_result_log

Interface
REQ-001 SHALL have port CLOCK_50  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle search-start pulse, same pulse that launches the binary search.
REQ-004 SHALL have port key_in  input  8  searched key, sampled when start=1.
REQ-005 SHALL have port done  input  1  search-complete level from the binary-search engine; may stay high for several cycles.
REQ-006 SHALL have port loc  input  5  result address from the engine, valid while done=1.
REQ-007 SHALL have port found  input  1  result hit flag from the engine, valid while done=1.
REQ-008 SHALL have port cycles  input  8  measured Start-to-Done cycle count, sampled at log time.
REQ-009 SHALL have ports next, prev, clear  input  1 each  one-cycle user pulses: view older entry, view newer entry, wipe log.
REQ-010 SHALL have ports rd_key 8, rd_loc 5, rd_found 1, rd_cycles 8  output  fields of the entry being viewed.
REQ-011 SHALL have port rd_index  output  3  age of viewed entry; 0 = newest.
REQ-012 SHALL have ports count 4, empty 1, full 1  output  occupancy (0..8).
REQ-013 SHALL have ports hit_count 8, miss_count 8  output  saturating totals of logged hits/misses.

Function
REQ-014 SHALL store up to 8 entries {key, loc, found, cycles} in a circular buffer with 3-bit write pointer wr_ptr.
REQ-015 SHALL hold one pending register: start=1 latches key_in and sets pending; start while pending re-latches key_in (restart).
REQ-016 SHALL detect done rising edge (done=1, done_prev=0); log event = rising edge AND pending.
REQ-017 On log event SHALL write {pending key, loc, found, cycles} at wr_ptr, wr_ptr <= wr_ptr+1 mod 8, clear pending, rd_index <= 0.
REQ-018 count SHALL increment on each log event and saturate at 8; at count=8 a log overwrites the oldest entry.
REQ-019 done rising edge with pending=0 SHALL be ignored; done held high SHALL log exactly once.
REQ-020 On log event SHALL increment hit_count if found=1 else miss_count, each saturating at 255.
REQ-021 Viewed entry SHALL be mem[(wr_ptr-1-rd_index) mod 8]; read outputs combinational from registered state, so a new entry is visible the cycle after the log edge.
REQ-022 next SHALL increment rd_index only if rd_index < count-1; prev SHALL decrement only if rd_index > 0; otherwise hold.
REQ-023 next and prev in same cycle SHALL leave rd_index unchanged.
REQ-024 Log event in same cycle as next/prev SHALL take priority: rd_index <= 0.
REQ-025 clear SHALL set count, wr_ptr, rd_index, hit_count, miss_count to 0 and clear pending; clear beats log event and start in same cycle.
REQ-026 When count=0 SHALL drive rd_key, rd_loc, rd_found, rd_cycles to 0 regardless of memory contents.
REQ-027 empty SHALL equal (count==0); full SHALL equal (count==8).
REQ-028 start and done rising edge in the same cycle SHALL log the previously pending key, then leave pending set with the new key.

Reset
REQ-029 reset SHALL clear wr_ptr, rd_index, count, hit_count, miss_count, pending, done_prev; outputs: empty=1, full=0, all rd_* =0.
REQ-030 reset mid-search SHALL discard pending; a subsequent done edge without new start SHALL not log.
REQ-031 Buffer memory contents need not be reset; REQ-026 masks them.

Verification
REQ-032 reset; start key 0x2A; done high 3 cycles with loc=5, found=1, cycles=6 -> one entry: rd_key=0x2A, rd_loc=5, rd_found=1, rd_cycles=6, count=1, hit_count=1.
REQ-033 10 start/done pairs keys 0x01..0x0A, alternating found -> count=8, full=1, rd_key=0x0A; 7 next pulses -> rd_key=0x03, rd_index=7; 8th next -> unchanged; hit_count=5, miss_count=5.
REQ-034 done edge with no prior start -> count unchanged, no counter change; start then reset then done -> count=0, empty=1.
REQ-035 with 3 entries, rd_index=2, next+prev same cycle -> rd_index=2; prev with log event same cycle -> rd_index=0, rd_key=new key.
REQ-036 clear asserted same cycle as done edge with pending -> count=0, hit_count=0, miss_count=0, rd_* =0.
REQ-037 256 logged hits -> hit_count=255 (saturated), miss_count=0.
